// File: rtl/bus_pkg.sv
// Shared definitions for the bus transaction controller: FSM encoding,
// header field layout, controller ID and parameter defaults.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_TURN = 3'd2,
    ST_DATA = 3'd3,
    ST_ACK  = 3'd4
  } state_t;

  localparam int HDR_OP_LSB  = 0;
  localparam int HDR_SRC_LSB = 2;
  localparam int HDR_DST_LSB = 4;

  localparam logic [1:0] CTRL_ID = 2'b11;

  localparam int TURN_CYCLES_DEF    = 3;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dst;
    logic [1:0] op;
    logic [7:0] len;
  } req_t;

endpackage

// File: rtl/bus_txn_ctrl_if.sv
// Request handshake, shared-bus and completion signals of bus_txn_ctrl.
// master = requester/bus side, slave = the controller.
interface bus_txn_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_src;
  logic [1:0] req_dst;
  logic [1:0] req_op;
  logic [7:0] req_len;
  logic [7:0] bus_data_out;
  logic       bus_valid_out;
  logic       bus_drive_en;
  logic [7:0] bus_data_in;
  logic       bus_valid_in;
  logic       ack;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       done;
  logic       err;

  modport slave (
    input  req_valid, req_src, req_dst, req_op, req_len, bus_data_in, bus_valid_in,
    output req_ready, bus_data_out, bus_valid_out, bus_drive_en, ack, rx_valid,
           rx_data, done, err
  );

  modport master (
    output req_valid, req_src, req_dst, req_op, req_len, bus_data_in, bus_valid_in,
    input  req_ready, bus_data_out, bus_valid_out, bus_drive_en, ack, rx_valid,
           rx_data, done, err
  );
endinterface

// File: rtl/bus_hdr_pack.sv
// Combinational header formatter: {2'b00, dst, src, op} while enabled, else 0.
module bus_hdr_pack
  import bus_pkg::*;
(
  input  logic       i_en,
  input  logic [1:0] i_src,
  input  logic [1:0] i_dst,
  input  logic [1:0] i_op,
  output logic [7:0] o_data
);

  always_comb begin
    o_data = 8'h00;
    if (i_en) begin
      o_data[HDR_DST_LSB +: 2] = i_dst;
      o_data[HDR_SRC_LSB +: 2] = i_src;
      o_data[HDR_OP_LSB  +: 2] = i_op;
    end
  end

endmodule

// File: rtl/bus_txn_ctrl.sv
// Shared-bus transaction controller: header beat, turnaround, data beats, ack.
// Optional feature: define BUS_TXN_TIMEOUT_EN to abort a stalled DATA phase.
module bus_txn_ctrl
  import bus_pkg::*;
#(
  parameter int TURN_CYCLES    = TURN_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  bus_txn_ctrl_if.slave bus
);

  localparam int TW = $clog2(TURN_CYCLES + 1);

  if (TURN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("bus_txn_ctrl: TURN_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  state_t         r_state, w_next;
  req_t           r_req;
  logic [TW-1:0]  r_turn;
  logic [7:0]     r_cnt;
  logic           r_err;
  logic           r_rx_valid;
  logic [7:0]     r_rx_data;

  logic           w_accept;
  logic           w_beat;
  logic           w_turn_end;
  logic           w_timeout;
  logic [7:0]     w_cnt_nxt;
  logic [7:0]     w_hdr;

  assign w_accept   = (r_state == ST_IDLE) && bus.req_valid;
  // Beats seen during turnaround count too; they only flag the error.
  assign w_beat     = ((r_state == ST_TURN) || (r_state == ST_DATA)) && bus.bus_valid_in;
  assign w_turn_end = (r_state == ST_TURN) && (r_turn == TW'(TURN_CYCLES - 1));
  assign w_cnt_nxt  = (w_beat && (r_cnt != 8'hFF)) ? r_cnt + 8'd1 : r_cnt;

`ifdef BUS_TXN_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] r_idle;

  assign w_timeout = (r_state == ST_DATA) && !bus.bus_valid_in &&
                     (r_idle == IW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                                 r_idle <= '0;
    else if ((r_state != ST_DATA) || w_beat) r_idle <= '0;
    else                                     r_idle <= r_idle + IW'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.req_valid) w_next = ST_HDR;
      ST_HDR:  w_next = ST_TURN;
      ST_TURN: if (w_turn_end) w_next = (w_cnt_nxt >= r_req.len) ? ST_ACK : ST_DATA;
      ST_DATA: if ((w_beat && (w_cnt_nxt >= r_req.len)) || w_timeout) w_next = ST_ACK;
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req      <= '0;
      r_turn     <= '0;
      r_cnt      <= 8'h00;
      r_err      <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
    end else begin
      if (w_accept) begin
        r_req  <= '{src: bus.req_src, dst: bus.req_dst, op: bus.req_op, len: bus.req_len};
        r_turn <= '0;
        r_cnt  <= 8'h00;
        r_err  <= 1'b0;
      end else begin
        if (r_state == ST_TURN) r_turn <= r_turn + TW'(1);
        r_cnt <= w_cnt_nxt;
        if (((r_state == ST_TURN) && w_beat) || w_timeout) r_err <= 1'b1;
      end
      r_rx_valid <= w_beat;
      r_rx_data  <= w_beat ? bus.bus_data_in : 8'h00;
    end
  end

  bus_hdr_pack u_hdr (
    .i_en   (r_state == ST_HDR),
    .i_src  (r_req.src),
    .i_dst  (r_req.dst),
    .i_op   (r_req.op),
    .o_data (w_hdr)
  );

  always_comb begin
    bus.req_ready     = (r_state == ST_IDLE) && !rst;
    bus.bus_drive_en  = (r_state == ST_HDR);
    bus.bus_valid_out = (r_state == ST_HDR);
    bus.bus_data_out  = w_hdr;
    bus.ack           = (r_state == ST_ACK);
    bus.done          = (r_state == ST_ACK);
    bus.err           = (r_state == ST_ACK) && r_err;
    bus.rx_valid      = r_rx_valid;
    bus.rx_data       = r_rx_data;
  end

endmodule

// File: tb/tb_bus_txn_ctrl.sv
// Scoreboard bench for bus_txn_ctrl: the driver schedules each transaction from
// the protocol timing rules and queues expected events; a monitor checks them.
module tb_bus_txn_ctrl;
  import bus_pkg::*;

  localparam int T  = TURN_CYCLES_DEF;
  localparam int TO = 8;

  typedef struct {
    int cyc;
    int data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   next_free = 0;
  bit   mon_en = 1'b0;
  ev_t  hdr_q[$], rx_q[$], done_q[$];

  bus_txn_ctrl_if bif ();

  bus_txn_ctrl #(.TURN_CYCLES(T), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: output seen with nothing expected (cycle %0d)", nm, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (bif.bus_drive_en) begin
        if (hdr_q.size() == 0) unexpected("hdr");
        else begin
          e = hdr_q.pop_front();
          chk("hdr_cycle", cyc, e.cyc);
          chk("hdr_data", int'(bif.bus_data_out), e.data);
          chk("hdr_valid", int'(bif.bus_valid_out), 1);
        end
      end else begin
        chk("idle_bus_data", int'(bif.bus_data_out), 0);
        chk("idle_bus_valid", int'(bif.bus_valid_out), 0);
      end
      if (bif.rx_valid) begin
        if (rx_q.size() == 0) unexpected("rx");
        else begin
          e = rx_q.pop_front();
          chk("rx_cycle", cyc, e.cyc);
          chk("rx_data", int'(bif.rx_data), e.data);
        end
      end
      if (bif.done) begin
        if (done_q.size() == 0) unexpected("done");
        else begin
          e = done_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_err", int'(bif.err), e.data);
          chk("done_ack", int'(bif.ack), 1);
        end
      end else begin
        chk("ack_without_done", int'(bif.ack), 0);
      end
    end
  end

  // One transaction. Acceptance happens at the first free IDLE cycle; beats
  // may arrive early (in turnaround), continuously or with random gaps.
  task automatic run_txn(input logic [1:0] s, input logic [1:0] d, input logic [1:0] o,
                         input int len, input bit early, input bit cont,
                         input bit junk, input int max_beats);
    int h, c, err, idle, bd, early_at, dv;
    bit beat;
    bif.req_valid = 1'b1;
    bif.req_src = s;
    bif.req_dst = d;
    bif.req_op  = o;
    bif.req_len = 8'(len);
    h = ((cyc > next_free) ? cyc : next_free) + 1;
    while (cyc < h) step();
    bif.req_valid = 1'b0;
    bif.req_src = 2'($urandom);
    bif.req_dst = 2'($urandom);
    bif.req_op  = 2'($urandom);
    bif.req_len = 8'($urandom);
    bif.bus_valid_in = 1'b0;
    hdr_q.push_back('{h, int'(d) * 16 + int'(s) * 4 + int'(o)});
    c = 0; err = 0; idle = 0; bd = 0;
    early_at = early ? int'($urandom_range(1, T)) : 0;
    for (int i = 1; i <= T; i++) begin
      step();
      dv = int'($urandom_range(0, 255));
      bif.bus_data_in  = 8'(dv);
      bif.bus_valid_in = (i == early_at);
      if (i == early_at) begin
        c++;
        err = 1;
        rx_q.push_back('{cyc + 1, dv});
      end
    end
    step();
    if (c < len) begin
      forever begin
        beat = (bd < max_beats) && (cont || ($urandom_range(0, 3) != 0));
        dv = int'($urandom_range(0, 255));
        bif.bus_data_in  = 8'(dv);
        bif.bus_valid_in = beat;
        if (beat) begin
          c++; bd++; idle = 0;
          rx_q.push_back('{cyc + 1, dv});
          if (c == len) begin
            step();
            break;
          end
        end else begin
          idle++;
`ifdef BUS_TXN_TIMEOUT_EN
          if (idle == TO) begin
            err = 1;
            step();
            break;
          end
`endif
        end
        step();
      end
    end
    // Now in the ACK cycle; junk beats here must be ignored.
    done_q.push_back('{cyc, err});
    next_free = cyc + 1;
    bif.bus_valid_in = junk;
    bif.bus_data_in  = 8'($urandom);
  endtask

  // Reset two beats into a four-beat DATA phase.
  task automatic run_reset_txn();
    int h, a, dv;
    bif.req_valid = 1'b1;
    bif.req_src = 2'd1; bif.req_dst = 2'd2; bif.req_op = 2'd3; bif.req_len = 8'd4;
    h = ((cyc > next_free) ? cyc : next_free) + 1;
    while (cyc < h) step();
    bif.req_valid = 1'b0;
    bif.bus_valid_in = 1'b0;
    hdr_q.push_back('{h, 2 * 16 + 1 * 4 + 3});
    repeat (T) step();
    step();
    a = cyc;
    for (int i = 0; i < 2; i++) begin
      dv = int'($urandom_range(0, 255));
      bif.bus_data_in = 8'(dv);
      bif.bus_valid_in = 1'b1;
      rx_q.push_back('{a + i + 1, dv});
      step();
    end
    rst = 1'b1;
    bif.bus_valid_in = 1'b1;
    @(negedge clk);
    chk("rst_req_ready_low", int'(bif.req_ready), 0);
    step();
    bif.bus_valid_in = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", int'(bif.req_ready), 0);
    chk("rst_ack", int'(bif.ack), 0);
    chk("rst_done", int'(bif.done), 0);
    chk("rst_err", int'(bif.err), 0);
    chk("rst_rx_valid", int'(bif.rx_valid), 0);
    chk("rst_rx_data", int'(bif.rx_data), 0);
    chk("rst_drive_en", int'(bif.bus_drive_en), 0);
    chk("rst_bus_data", int'(bif.bus_data_out), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", int'(bif.req_ready), 1);
    next_free = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bif.req_valid = 1'b0;
    bif.req_src = 2'd0; bif.req_dst = 2'd0; bif.req_op = 2'd0; bif.req_len = 8'd0;
    bif.bus_data_in = 8'h00;
    bif.bus_valid_in = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", int'(bif.req_ready), 0);
    chk("reset_done", int'(bif.done), 0);
    chk("reset_rx_valid", int'(bif.rx_valid), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_release_req_ready", int'(bif.req_ready), 1);
    next_free = cyc;

    run_txn(2'd1, 2'd2, 2'd1, 4, 1'b0, 1'b1, 1'b0, 1000);
    step();
    run_txn(2'd0, 2'd3, 2'd2, 0, 1'b0, 1'b0, 1'b0, 1000);
    run_txn(2'd3, 2'd0, 2'd2, 255, 1'b0, 1'b1, 1'b1, 1000);
    repeat (2) step();
    run_reset_txn();
    run_txn(2'd2, 2'd1, 2'd0, 3, 1'b1, 1'b0, 1'b1, 1000);
    run_txn(2'd1, 2'd3, 2'd3, 2, 1'b0, 1'b1, 1'b0, 1000);
`ifdef BUS_TXN_TIMEOUT_EN
    run_txn(2'd1, 2'd1, 2'd1, 3, 1'b0, 1'b1, 1'b0, 1);
`endif
    for (int k = 0; k < 30; k++) begin
      run_txn(2'($urandom), 2'($urandom), 2'($urandom), int'($urandom_range(0, 12)),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
              ($urandom_range(0, 1) == 0), 1000);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) step();
    end

    bif.bus_valid_in = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("hdr_queue_drained", hdr_q.size(), 0);
    chk("rx_queue_drained", rx_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
